dump_sequencer: RTL and testbench

//  Sequences a DUMP_CH command: fetches offset and gain calibration for the selected channel from the

---
 rtl/dso_pkg.sv | 32 +++
 rtl/dump_sequencer_if.sv | 42 ++++
 rtl/dump_sequencer.sv | 171 +++++++++++++++++
 tb/tb_dump_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dso_pkg.sv
// Shared DSO definitions: dump sequencer states, EEPROM SPI constants and channel codes.
// The channel codes are also used by the command decoder.
package dso_pkg;

  localparam logic [2:0]  EEP_SS = 3'b100;
  localparam logic [15:0] DUMMY  = 16'hBCBC;
  localparam logic [1:0]  EEP_RD = 2'b00;

  localparam logic [1:0] CH1     = 2'b00;
  localparam logic [1:0] CH2     = 2'b01;
  localparam logic [1:0] CH3     = 2'b10;
  localparam logic [1:0] CH_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    OFF_CMD,
    OFF_DAT,
    GN_CMD,
    GN_DAT,
    RD,
    SEND,
    WAIT_TX
  } dump_state_t;

  // EEPROM address is {channel, gain code, sel}; sel=0 offset, sel=1 gain.
  function automatic logic [15:0] eep_rd_cmd(input logic [1:0] ch,
                                             input logic [2:0] gain,
                                             input logic       sel);
    return {EEP_RD, ch, gain, sel, 8'h00};
  endfunction

endpackage

// File: rtl/dump_sequencer_if.sv
// Command, SPI master, capture RAM and UART response signals of the dump sequencer.
// master = the sequencer itself, slave = decoder/SPI/RAM/UART side.
interface dump_sequencer_if #(
  parameter int AW = 9
) ();

  logic          dump;
  logic [1:0]    dump_ch;
  logic [2:0]    ch1_AFEgain;
  logic [2:0]    ch2_AFEgain;
  logic [2:0]    ch3_AFEgain;
  logic [AW-1:0] trig_addr;
  logic          SPI_done;
  logic          resp_sent;

  logic          wrt_SPI;
  logic [15:0]   SPI_data;
  logic [2:0]    ss;
  logic          flopOffset;
  logic          flopGain;
  logic [AW-1:0] ram_addr;
  logic [2:0]    ram_re;
  logic          send_resp;
  logic          busy;
  logic          dump_done;
  logic          dump_err;

  modport master (
    input  dump, dump_ch, ch1_AFEgain, ch2_AFEgain, ch3_AFEgain, trig_addr,
           SPI_done, resp_sent,
    output wrt_SPI, SPI_data, ss, flopOffset, flopGain, ram_addr, ram_re,
           send_resp, busy, dump_done, dump_err
  );

  modport slave (
    output dump, dump_ch, ch1_AFEgain, ch2_AFEgain, ch3_AFEgain, trig_addr,
           SPI_done, resp_sent,
    input  wrt_SPI, SPI_data, ss, flopOffset, flopGain, ram_addr, ram_re,
           send_resp, busy, dump_done, dump_err
  );

endinterface

// File: rtl/dump_sequencer.sv
// DUMP_CH sequencer: reads offset/gain calibration from the EEPROM over SPI, then streams
// the selected channel's capture RAM to the UART once, starting at the oldest sample.
module dump_sequencer
  import dso_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  dump_sequencer_if.master bus
);

  dump_state_t   state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [2:0]    gain_q, gain_d;
  logic [AW-1:0] trig_q, trig_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [15:0]   spiData_q, spiData_d;
  logic [2:0]    ss_q, ss_d;
  logic          wrt_q, wrt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          flopOffset;
  logic          flopGain;
  logic [2:0]    ramRe;
  logic          sendResp;
  logic [2:0]    selGain;

  always_comb begin
    case (bus.dump_ch)
      CH1:     selGain = bus.ch1_AFEgain;
      CH2:     selGain = bus.ch2_AFEgain;
      default: selGain = bus.ch3_AFEgain;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ch_q      <= 2'b00;
      gain_q    <= 3'b000;
      trig_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      spiData_q <= 16'h0000;
      ss_q      <= 3'b000;
      wrt_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      gain_q    <= gain_d;
      trig_q    <= trig_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      spiData_q <= spiData_d;
      ss_q      <= ss_d;
      wrt_q     <= wrt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // wrt_SPI is registered together with SPI_data so the command word is valid on the strobe;
  // flopOffset/flopGain must be combinational because EEP_data is only valid with SPI_done.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    gain_d     = gain_q;
    trig_d     = trig_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    spiData_d  = spiData_q;
    ss_d       = ss_q;
    wrt_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    flopOffset = 1'b0;
    flopGain   = 1'b0;
    ramRe      = 3'b000;
    sendResp   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.dump) begin
          if (bus.dump_ch == CH_RSVD) begin
            err_d = 1'b1;
          end else begin
            ch_d      = bus.dump_ch;
            gain_d    = selGain;
            trig_d    = bus.trig_addr;
            spiData_d = eep_rd_cmd(bus.dump_ch, selGain, 1'b0);
            ss_d      = EEP_SS;
            wrt_d     = 1'b1;
            cnt_d     = '0;
            state_d   = OFF_CMD;
          end
        end
      end
      OFF_CMD: begin
        if (bus.SPI_done) begin
          spiData_d = DUMMY;
          wrt_d     = 1'b1;
          state_d   = OFF_DAT;
        end
      end
      OFF_DAT: begin
        if (bus.SPI_done) begin
          flopOffset = 1'b1;
          spiData_d  = eep_rd_cmd(ch_q, gain_q, 1'b1);
          wrt_d      = 1'b1;
          state_d    = GN_CMD;
        end
      end
      GN_CMD: begin
        if (bus.SPI_done) begin
          spiData_d = DUMMY;
          wrt_d     = 1'b1;
          state_d   = GN_DAT;
        end
      end
      GN_DAT: begin
        if (bus.SPI_done) begin
          flopGain = 1'b1;
          addr_d   = trig_q;
          state_d  = RD;
        end
      end
      RD: begin
        ramRe   = 3'(3'b001 << ch_q);
        state_d = SEND;
      end
      SEND: begin
        sendResp = 1'b1;
        state_d  = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.resp_sent) begin
          // Terminal check precedes the increment, so cnt never has to hold DEPTH.
          if (cnt_q == AW'(DEPTH - 1)) begin
            done_d  = 1'b1;
            ss_d    = 3'b000;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.wrt_SPI    = wrt_q;
  assign bus.SPI_data   = spiData_q;
  assign bus.ss         = ss_q;
  assign bus.flopOffset = flopOffset;
  assign bus.flopGain   = flopGain;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_re     = ramRe;
  assign bus.send_resp  = sendResp;
  assign bus.busy       = (state_q != IDLE);
  assign bus.dump_done  = done_q;
  assign bus.dump_err   = err_q;

endmodule

// File: tb/tb_dump_sequencer.sv
// Self-checking bench for dump_sequencer: vector table of dumps plus hand-written corner sequences,
// with SPI/UART responders popping expected SPI words and RAM addresses from scoreboard queues.
module tb_dump_sequencer;

  localparam int AW    = 9;
  localparam int DEPTH = 512;

  typedef struct {
    logic [1:0]  ch;
    logic [2:0]  gain;
    logic [8:0]  trig;
    logic [15:0] offWord;
    logic [15:0] gainWord;
    logic [2:0]  re;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dump_sequencer_if #(.AW(AW)) bus ();

  dump_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [15:0] spiQ[$];
  logic [8:0]  addrQ[$];
  logic [2:0]  expRe = 3'b000;
  int          sendCount = 0;
  int          doneCount = 0;
  int          errCount = 0;
  int          wrtSeen = 0;
  int          spiDoneIdx = 0;
  int          spiTimer = 0;
  int          respTimer = 0;
  int          respDelay = 2;
  bit          forceResp = 1'b0;
  bit          injectSpi = 1'b0;
  bit          injected = 1'b0;
  vec_t        vecs[5];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_wrt_SPI"},   16'(bus.wrt_SPI),    16'd0);
    checkOutput({tag, "_SPI_data"},  bus.SPI_data,        16'h0000);
    checkOutput({tag, "_ss"},        16'(bus.ss),         16'd0);
    checkOutput({tag, "_flopOff"},   16'(bus.flopOffset), 16'd0);
    checkOutput({tag, "_flopGain"},  16'(bus.flopGain),   16'd0);
    checkOutput({tag, "_ram_addr"},  16'(bus.ram_addr),   16'd0);
    checkOutput({tag, "_ram_re"},    16'(bus.ram_re),     16'd0);
    checkOutput({tag, "_send_resp"}, 16'(bus.send_resp),  16'd0);
    checkOutput({tag, "_busy"},      16'(bus.busy),       16'd0);
    checkOutput({tag, "_dump_done"}, 16'(bus.dump_done),  16'd0);
    checkOutput({tag, "_dump_err"},  16'(bus.dump_err),   16'd0);
  endtask

  // Drives one dump pulse and queues every SPI word and RAM address it should produce.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #2;
    bus.dump_ch     = v.ch;
    bus.ch1_AFEgain = (v.ch == 2'b00) ? v.gain : ~v.gain;
    bus.ch2_AFEgain = (v.ch == 2'b01) ? v.gain : ~v.gain;
    bus.ch3_AFEgain = (v.ch == 2'b10) ? v.gain : ~v.gain;
    bus.trig_addr   = v.trig;
    if (!v.err) begin
      spiQ.push_back(v.offWord);
      spiQ.push_back(16'hBCBC);
      spiQ.push_back(v.gainWord);
      spiQ.push_back(16'hBCBC);
      for (int i = 0; i < DEPTH; i++) addrQ.push_back(9'(v.trig + 9'(i)));
      expRe = v.re;
    end
    bus.dump = 1'b1;
    @(posedge clk);
    #2;
    bus.dump        = 1'b0;
    bus.trig_addr   = ~v.trig;
    bus.ch1_AFEgain = 3'($urandom);
    bus.ch2_AFEgain = 3'($urandom);
    bus.ch3_AFEgain = 3'($urandom);
  endtask

  task automatic waitDone(input int startDone, input string name);
    int cyc = 0;
    while (doneCount == startDone && cyc < 6000) begin
      @(posedge clk);
      cyc++;
    end
    checkOutput({name, "_done_pulses"}, 16'(doneCount - startDone), 16'd1);
  endtask

  task automatic runVector(input vec_t v, input string name);
    int startSend = sendCount;
    int startDone = doneCount;
    int startErr  = errCount;
    applyStimulus(v);
    if (v.err) begin
      checkOutput({name, "_dump_err"}, 16'(bus.dump_err), 16'd1);
      checkOutput({name, "_busy"},     16'(bus.busy),     16'd0);
      checkOutput({name, "_wrt_SPI"},  16'(bus.wrt_SPI),  16'd0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput({name, "_err_pulses"}, 16'(errCount - startErr), 16'd1);
      checkOutput({name, "_no_sends"},   16'(sendCount - startSend), 16'd0);
      checkOutput({name, "_still_idle"}, 16'(bus.busy), 16'd0);
    end else begin
      checkOutput({name, "_busy_start"}, 16'(bus.busy), 16'd1);
      waitDone(startDone, name);
      #1;
      checkOutput({name, "_busy_end"},   16'(bus.busy), 16'd0);
      checkOutput({name, "_sends"},      16'(sendCount - startSend), 16'(DEPTH));
      checkOutput({name, "_addr_left"},  16'(addrQ.size()), 16'd0);
      checkOutput({name, "_spi_left"},   16'(spiQ.size()), 16'd0);
      checkOutput({name, "_no_err"},     16'(errCount - startErr), 16'd0);
    end
  endtask

  // SPI slave and UART model: answers wrt_SPI/send_resp and compares against the scoreboard.
  initial begin : responder
    logic [15:0] expWord;
    logic [8:0]  expAddr;
    bus.SPI_done  = 1'b0;
    bus.resp_sent = 1'b0;
    forever begin
      @(negedge clk);
      bus.SPI_done  = 1'b0;
      bus.resp_sent = forceResp;
      injected      = 1'b0;
      if (rst) begin
        spiTimer  = 0;
        respTimer = 0;
      end else begin
        if (!bus.busy) begin
          spiDoneIdx = 0;
          wrtSeen    = 0;
        end
        if (bus.ram_re != 3'b000) begin
          if (forceResp) begin
            forceResp     = 1'b0;
            bus.resp_sent = 1'b0;
          end
          if (addrQ.size() == 0) begin
            checkOutput("ram_extra", 16'(bus.ram_re), 16'd0);
          end else begin
            expAddr = addrQ.pop_front();
            checkOutput("ram_addr", 16'(bus.ram_addr), 16'(expAddr));
            checkOutput("ram_re",   16'(bus.ram_re),   16'(expRe));
          end
        end
        if (bus.send_resp) begin
          sendCount++;
          respTimer = respDelay;
        end
        if (bus.wrt_SPI) begin
          wrtSeen++;
          if (spiQ.size() == 0) begin
            checkOutput("spi_extra", 16'(bus.wrt_SPI), 16'd0);
          end else begin
            expWord = spiQ.pop_front();
            checkOutput("spi_word", bus.SPI_data, expWord);
            checkOutput("spi_ss",   16'(bus.ss),  16'h0004);
          end
          spiTimer = 3;
        end
        if (bus.dump_done) doneCount++;
        if (bus.dump_err)  errCount++;
        if (spiTimer > 0) begin
          spiTimer--;
          if (spiTimer == 0) begin
            bus.SPI_done = 1'b1;
            spiDoneIdx++;
          end
        end
        if (respTimer > 0) begin
          respTimer--;
          if (respTimer == 0) begin
            bus.resp_sent = 1'b1;
          end else if (respTimer == 1 && injectSpi) begin
            bus.SPI_done = 1'b1;
            injected     = 1'b1;
          end
        end
        #1;
        if (bus.SPI_done) begin
          if (injected) begin
            checkOutput("stray_flopOffset", 16'(bus.flopOffset), 16'd0);
            checkOutput("stray_flopGain",   16'(bus.flopGain),   16'd0);
          end else begin
            checkOutput("flopOffset", 16'(bus.flopOffset), 16'(spiDoneIdx == 2));
            checkOutput("flopGain",   16'(bus.flopGain),   16'(spiDoneIdx == 4));
          end
        end
      end
    end
  end

  initial begin : main
    int startDone;
    int startErr;
    int cyc;
    bit seen;

    vecs[0] = '{2'b01, 3'b101, 9'h1F0, 16'h1A00, 16'h1B00, 3'b010, 1'b0};
    vecs[1] = '{2'b11, 3'b010, 9'h055, 16'h0000, 16'h0000, 3'b000, 1'b1};
    vecs[2] = '{2'b00, 3'b011, 9'h000, 16'h0600, 16'h0700, 3'b001, 1'b0};
    vecs[3] = '{2'b10, 3'b111, 9'h1FF, 16'h2E00, 16'h2F00, 3'b100, 1'b0};
    vecs[4] = '{2'b11, 3'b111, 9'h100, 16'h0000, 16'h0000, 3'b000, 1'b1};

    rst             = 1'b1;
    bus.dump        = 1'b0;
    bus.dump_ch     = 2'b00;
    bus.ch1_AFEgain = 3'b000;
    bus.ch2_AFEgain = 3'b000;
    bus.ch3_AFEgain = 3'b000;
    bus.trig_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] dump pulse while busy");
    startDone = doneCount;
    startErr  = errCount;
    applyStimulus(vecs[0]);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      #2;
      if (bus.send_resp && sendCount > 100) seen = 1'b1;
      cyc++;
    end
    checkOutput("busy_dump_reached_send", 16'(seen), 16'd1);
    @(posedge clk);
    #2;
    bus.dump    = 1'b1;
    bus.dump_ch = 2'b00;
    @(posedge clk);
    #2;
    bus.dump = 1'b0;
    waitDone(startDone, "busy_dump");
    #1;
    checkOutput("busy_dump_no_err",   16'(errCount - startErr), 16'd0);
    checkOutput("busy_dump_addr_left", 16'(addrQ.size()), 16'd0);

    $display("[TB] reset in GN_CMD");
    startDone = doneCount;
    applyStimulus(vecs[3]);
    cyc = 0;
    while (wrtSeen < 3 && cyc < 200) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    checkOutput("rst_reached_gn_cmd", 16'(wrtSeen), 16'd3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    spiQ.delete();
    addrQ.delete();
    @(posedge clk);
    #1;
    checkIdle("rst_mid");
    #1;
    rst = 1'b0;
    checkOutput("rst_no_done", 16'(doneCount - startDone), 16'd0);
    runVector(vecs[3], "after_rst");

    $display("[TB] stray resp_sent and SPI_done");
    forceResp = 1'b1;
    injectSpi = 1'b1;
    respDelay = 3;
    runVector(vecs[2], "stray");
    injectSpi = 1'b0;
    respDelay = 2;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
